// File: rtl/writeback_select_stage.sv
// Write-back source select with a main/skid register pair and hazard/forward taps (fwd built only with WB_FORWARD_EN).
// Latency: 1 cycle input-to-output when main is empty or draining; skid absorbs one extra bundle.
// Backpressure: in_ready is registered as !skid.valid, so upstream stalls only after two bundles are held.
module writeback_select_stage #(
    parameter int DATA_W = 32,
    parameter int NSRC   = 4,
    parameter int SEL_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NSRC*DATA_W-1:0] src_data,
    input  logic [SEL_W-1:0]       sel,
    input  logic [4:0]             rd_addr,
    input  logic                   rd_we,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      wb_data,
    output logic [4:0]             wb_rd,
    output logic                   wb_we,
    input  logic [4:0]             rs1_q,
    input  logic [4:0]             rs2_q,
    output logic                   hz1,
    output logic                   hz2,
    output logic [DATA_W-1:0]      fwd1,
    output logic [DATA_W-1:0]      fwd2
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [4:0]        rd;
        logic              we;
        logic              valid;
    } entry_t;

    entry_t      main_q;
    entry_t      skid_q;
    entry_t      cap;
    logic        ready_q;
    logic [31:0] sel_idx;
    logic        accept;
    logic        drain;
    logic        skid_next_valid;

    // An out-of-range select captures a dead bundle: zero data, no write.
    always_comb begin
        cap       = '0;
        cap.valid = 1'b1;
        cap.rd    = rd_addr;
        sel_idx   = 32'(sel);
        for (int k = 0; k < NSRC; k++) begin
            if (sel_idx == 32'(k)) begin
                cap.data = src_data[k*DATA_W +: DATA_W];
                cap.we   = rd_we && (rd_addr != 5'd0);
            end
        end
    end

    assign accept = in_valid && ready_q;
    assign drain  = main_q.valid && out_ready;

    // skid only fills when main is occupied and stuck; ready_q tracks that one edge ahead
    assign skid_next_valid = !drain && (skid_q.valid || (accept && main_q.valid));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            if (drain) begin
                if (skid_q.valid) begin
                    main_q       <= skid_q;
                    skid_q.valid <= 1'b0;
                end else if (accept) begin
                    main_q <= cap;
                end else begin
                    main_q.valid <= 1'b0;
                end
            end else if (accept) begin
                if (main_q.valid) begin
                    skid_q <= cap;
                end else begin
                    main_q <= cap;
                end
            end
            ready_q <= !skid_next_valid;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = main_q.valid;
    assign wb_data   = main_q.data;
    assign wb_rd     = main_q.rd;
    assign wb_we     = main_q.we;

    function automatic logic hit(input entry_t e, input logic [4:0] rs);
        return e.valid && e.we && (e.rd == rs) && (rs != 5'd0);
    endfunction

    logic m1, s1, m2, s2;
    assign m1  = hit(main_q, rs1_q);
    assign s1  = hit(skid_q, rs1_q);
    assign m2  = hit(main_q, rs2_q);
    assign s2  = hit(skid_q, rs2_q);
    assign hz1 = m1 || s1;
    assign hz2 = m2 || s2;

`ifdef WB_FORWARD_EN
    // skid holds the younger bundle, so its value wins
    assign fwd1 = s1 ? skid_q.data : (m1 ? main_q.data : '0);
    assign fwd2 = s2 ? skid_q.data : (m2 ? main_q.data : '0);
`else
    assign fwd1 = '0;
    assign fwd2 = '0;
`endif

endmodule

// File: tb/tb_writeback_select_stage.sv
// Bench for writeback_select_stage: directed scenarios plus a randomized run against a queue model.
module tb_writeback_select_stage;
    localparam int DW  = 64;
    localparam int NS  = 8;
    localparam int SW  = 4;
    localparam int BDW = 32;
    localparam int BNS = 3;
    localparam int BSW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             in_valid, in_ready, out_valid, out_ready, rd_we, wb_we, hz1, hz2;
    logic [NS*DW-1:0] src_data;
    logic [SW-1:0]    sel;
    logic [4:0]       rd_addr, wb_rd, rs1_q, rs2_q;
    logic [DW-1:0]    wb_data, fwd1, fwd2;

    logic               b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_rd_we, b_wb_we, b_hz1, b_hz2;
    logic [BNS*BDW-1:0] b_src_data;
    logic [BSW-1:0]     b_sel;
    logic [4:0]         b_rd_addr, b_wb_rd;
    logic [BDW-1:0]     b_wb_data, b_fwd1, b_fwd2;

    writeback_select_stage #(.DATA_W(DW), .NSRC(NS), .SEL_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .src_data(src_data), .sel(sel), .rd_addr(rd_addr), .rd_we(rd_we),
        .out_valid(out_valid), .out_ready(out_ready), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_we(wb_we), .rs1_q(rs1_q), .rs2_q(rs2_q), .hz1(hz1), .hz2(hz2),
        .fwd1(fwd1), .fwd2(fwd2)
    );

    writeback_select_stage #(.DATA_W(BDW), .NSRC(BNS), .SEL_W(BSW)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .src_data(b_src_data), .sel(b_sel), .rd_addr(b_rd_addr), .rd_we(b_rd_we),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .wb_data(b_wb_data), .wb_rd(b_wb_rd),
        .wb_we(b_wb_we), .rs1_q(5'd0), .rs2_q(5'd0), .hz1(b_hz1), .hz2(b_hz2),
        .fwd1(b_fwd1), .fwd2(b_fwd2)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [4:0]    rd;
        logic          we;
    } bun_t;

    bun_t q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [NS*DW-1:0] rand_src();
        logic [NS*DW-1:0] r;
        for (int i = 0; i < NS*DW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic put(input int s, input logic [DW-1:0] d, input logic [4:0] rd, input logic we);
        src_data = rand_src();
        if (s < NS) src_data[s*DW +: DW] = d;
        sel      = SW'(s);
        rd_addr  = rd;
        rd_we    = we;
        in_valid = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        total++; if ({out_valid, wb_we, hz1, hz2} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {out_valid, wb_we, hz1, hz2}); end
        total++; if ({wb_data, wb_rd} !== '0) begin bad++; $display("FAIL reset_data got=%h/%h exp=0", wb_data, wb_rd); end
        total++; if ({fwd1, fwd2} !== '0) begin bad++; $display("FAIL reset_fwd got=%h/%h exp=0", fwd1, fwd2); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        rst_n = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL release_in_ready_early got=%b exp=0", in_ready); end
        @(negedge clk);
        total++; if ({in_ready, b_in_ready} !== 2'b11) begin bad++; $display("FAIL release_in_ready got=%b exp=11", {in_ready, b_in_ready}); end
    endtask

    task automatic test_single();
        @(negedge clk);
        put(1, 64'hAA, 5'd5, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        total++; if (wb_data !== 64'hAA) begin bad++; $display("FAIL single_data got=%h exp=aa", wb_data); end
        total++; if ({wb_rd, wb_we} !== {5'd5, 1'b1}) begin bad++; $display("FAIL single_rd_we got=%0d/%b exp=5/1", wb_rd, wb_we); end
        @(negedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        @(negedge clk);
        put(2, 64'h11, 5'd3, 1'b1);
        @(negedge clk);
        put(2, 64'h22, 5'd4, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b exp=0", in_ready); end
        total++; if ({out_valid, wb_data} !== {1'b1, 64'h11}) begin bad++; $display("FAIL bp_first got=%b/%h exp=1/11", out_valid, wb_data); end
        @(negedge clk);
        #1;
        total++; if ({wb_data, wb_rd} !== {64'h11, 5'd3}) begin bad++; $display("FAIL bp_hold got=%h/%0d exp=11/3", wb_data, wb_rd); end
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        total++; if ({out_valid, wb_data, wb_rd} !== {1'b1, 64'h22, 5'd4}) begin bad++; $display("FAIL bp_second got=%b/%h/%0d exp=1/22/4", out_valid, wb_data, wb_rd); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%b exp=1", in_ready); end
        @(negedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_x0_and_range();
        @(negedge clk);
        put(2, 64'h5555, 5'd0, 1'b1);
        b_src_data  = '1;
        b_sel       = 2'd3;
        b_rd_addr   = 5'd9;
        b_rd_we     = 1'b1;
        b_in_valid  = 1'b1;
        b_out_ready = 1'b1;
        @(negedge clk);
        in_valid   = 1'b0;
        b_in_valid = 1'b0;
        #1;
        total++; if ({out_valid, wb_we, wb_data} !== {1'b1, 1'b0, 64'h5555}) begin bad++; $display("FAIL x0_we got=%b/%b/%h exp=1/0/5555", out_valid, wb_we, wb_data); end
        total++; if ({b_out_valid, b_wb_we, b_wb_rd} !== {1'b1, 1'b0, 5'd9}) begin bad++; $display("FAIL range_flags got=%b/%b/%0d exp=1/0/9", b_out_valid, b_wb_we, b_wb_rd); end
        total++; if (b_wb_data !== '0) begin bad++; $display("FAIL range_data got=%h exp=0", b_wb_data); end
        @(negedge clk);
    endtask

    task automatic test_hazard();
        logic [DW-1:0] exp_fwd;
`ifdef WB_FORWARD_EN
        exp_fwd = 64'h20;
`else
        exp_fwd = '0;
`endif
        out_ready = 1'b0;
        @(negedge clk);
        put(1, 64'h10, 5'd7, 1'b1);
        @(negedge clk);
        put(3, 64'h20, 5'd7, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        rs1_q    = 5'd7;
        rs2_q    = 5'd0;
        #1;
        total++; if (hz1 !== 1'b1) begin bad++; $display("FAIL hz1_match got=%b exp=1", hz1); end
        total++; if (fwd1 !== exp_fwd) begin bad++; $display("FAIL fwd1_young got=%h exp=%h", fwd1, exp_fwd); end
        total++; if ({hz2, fwd2} !== '0) begin bad++; $display("FAIL hz2_x0 got=%b/%h exp=0/0", hz2, fwd2); end
        rs2_q = 5'd3;
        #1;
        total++; if (hz2 !== 1'b0) begin bad++; $display("FAIL hz2_nomatch got=%b exp=0", hz2); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if ({out_valid, wb_we, hz1, in_ready} !== 4'b0) begin bad++; $display("FAIL midrst_flags got=%b exp=0000", {out_valid, wb_we, hz1, in_ready}); end
        total++; if ({wb_data, wb_rd, fwd1} !== '0) begin bad++; $display("FAIL midrst_data got=%h/%h/%h exp=0", wb_data, wb_rd, fwd1); end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            total++; if ({out_valid, hz1} !== 2'b00) begin bad++; $display("FAIL midrst_after%0d got=%b exp=00", i, {out_valid, hz1}); end
        end
    endtask

    task automatic test_random();
        int   nout = 0;
        int   cyc  = 0;
        int   s;
        bit   acc, drn, hz_e1, hz_e2;
        logic [DW-1:0] fw_e1, fw_e2;
        bun_t nb;
        q.delete();
        while (nout < 10000 && cyc < 80000) begin
            @(negedge clk);
            cyc++;
            s         = $urandom_range(15);
            src_data  = rand_src();
            sel       = SW'(s);
            rd_addr   = 5'($urandom_range(7));
            rd_we     = 1'($urandom);
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            rs1_q     = 5'($urandom_range(7));
            rs2_q     = 5'($urandom_range(7));
            #1;
            hz_e1 = 0; hz_e2 = 0; fw_e1 = '0; fw_e2 = '0;
            foreach (q[i]) begin
                if (q[i].we && q[i].rd == rs1_q && rs1_q != 0) begin hz_e1 = 1; fw_e1 = q[i].data; end
                if (q[i].we && q[i].rd == rs2_q && rs2_q != 0) begin hz_e2 = 1; fw_e2 = q[i].data; end
            end
`ifndef WB_FORWARD_EN
            fw_e1 = '0; fw_e2 = '0;
`endif
            total++; if (out_valid !== (q.size() > 0)) begin bad++; if (bad < 30) $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, out_valid, q.size() > 0); end
            total++; if (in_ready !== (q.size() < 2)) begin bad++; if (bad < 30) $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, in_ready, q.size() < 2); end
            total++; if ({hz1, hz2} !== {hz_e1, hz_e2}) begin bad++; if (bad < 30) $display("FAIL rnd_hz cyc=%0d got=%b exp=%b", cyc, {hz1, hz2}, {hz_e1, hz_e2}); end
            total++; if ({fwd1, fwd2} !== {fw_e1, fw_e2}) begin bad++; if (bad < 30) $display("FAIL rnd_fwd cyc=%0d got=%h/%h exp=%h/%h", cyc, fwd1, fwd2, fw_e1, fw_e2); end
            if (q.size() > 0) begin
                total++;
                if ({wb_data, wb_rd, wb_we} !== {q[0].data, q[0].rd, q[0].we}) begin
                    bad++;
                    if (bad < 30) $display("FAIL rnd_front cyc=%0d got=%h/%0d/%b exp=%h/%0d/%b", cyc, wb_data, wb_rd, wb_we, q[0].data, q[0].rd, q[0].we);
                end
            end
            acc = in_valid && (q.size() < 2);
            drn = out_ready && (q.size() > 0);
            nb.data = (s < NS) ? DW'(src_data >> (s*DW)) : '0;
            nb.rd   = rd_addr;
            nb.we   = rd_we && (rd_addr != 0) && (s < NS);
            @(posedge clk);
            if (drn) begin void'(q.pop_front()); nout++; end
            if (acc) q.push_back(nb);
        end
        total++;
        if (nout < 10000) begin bad++; $display("FAIL rnd_timeout got=%0d exp=10000 bundles", nout); end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        in_valid = 0; out_ready = 0; rd_we = 0; src_data = '0; sel = '0; rd_addr = '0;
        rs1_q = '0; rs2_q = '0;
        b_in_valid = 0; b_out_ready = 0; b_rd_we = 0; b_src_data = '0; b_sel = '0; b_rd_addr = '0;
        test_reset();
        test_single();
        test_backpressure();
        test_x0_and_range();
        test_hazard();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
